// File: rtl/song_pkg.sv
// Shared types and defaults for the song recorder.
package song_pkg;

  localparam int NOTES_DEFAULT = 32;
  localparam int LEAD_DEFAULT  = 4;

  typedef enum logic [1:0] {
    IDLE,
    COUNT_IN,
    RECORD,
    DONE
  } state_e;

endpackage

// File: rtl/song_recorder_press_latch.sv
// Per-lane press capture: rising-edge detector plus sticky latch for one beat slot.
module press_latch (
  input  logic clk,
  input  logic rst,
  input  logic button,
  input  logic clear,
  input  logic enable,
  output logic hit_now
);

  logic prev_q;
  logic latch_q, latch_d;
  logic rise;

  assign rise    = enable & button & ~prev_q;
  assign hit_now = latch_q | rise;

  // Clear has priority so a press on the closing beat is not carried into the next slot.
  always_comb begin
    latch_d = latch_q | rise;
    if (clear) latch_d = 1'b0;
  end

  // Previous button sample and sticky latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      prev_q  <= button;
      latch_q <= latch_d;
    end
  end

endmodule

// File: rtl/song_recorder.sv
// Two-lane chart recorder: count-in, per-beat slot capture, atomic commit of notes1/notes2.
module song_recorder
  import song_pkg::*;
#(
  parameter int NOTES = NOTES_DEFAULT,
  parameter int LEAD  = LEAD_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     beat,
  input  logic                     button_1,
  input  logic                     button_2,
  output logic [NOTES-1:0]         notes1,
  output logic [NOTES-1:0]         notes2,
  output logic                     recording,
  output logic                     counting,
  output logic                     done,
  output logic [$clog2(NOTES)-1:0] beat_idx,
  output logic [2:0]               count_left
);

  localparam int IW = $clog2(NOTES);

  state_e           state_q, state_d;
  logic [NOTES-1:0] work1_q, work1_d, work2_q, work2_d;
  logic [NOTES-1:0] notes1_q, notes1_d, notes2_q, notes2_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             hit1, hit2;
  logic             lat_en, lat_clear;

  assign lat_en    = (state_q == RECORD);
  assign lat_clear = ~lat_en | beat;

  press_latch u_lane1 (
    .clk     (clk),
    .rst     (rst),
    .button  (button_1),
    .clear   (lat_clear),
    .enable  (lat_en),
    .hit_now (hit1)
  );

  press_latch u_lane2 (
    .clk     (clk),
    .rst     (rst),
    .button  (button_2),
    .clear   (lat_clear),
    .enable  (lat_en),
    .hit_now (hit2)
  );

  // Next-state, counters, working shift registers and commit.
  always_comb begin
    state_d  = state_q;
    work1_d  = work1_q;
    work2_d  = work2_q;
    notes1_d = notes1_q;
    notes2_d = notes2_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = COUNT_IN;
          cnt_d   = 3'(LEAD);
          work1_d = '0;
          work2_d = '0;
          idx_d   = '0;
        end
      end
      COUNT_IN: begin
        if (beat) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RECORD;
        end
      end
      RECORD: begin
        if (beat) begin
          work1_d[NOTES-1-int'(idx_q)] = hit1;
          work2_d[NOTES-1-int'(idx_q)] = hit2;
          if (idx_q == IW'(NOTES-1)) begin
            // Commit the chart including the bit closed on this very beat.
            notes1_d = work1_d;
            notes2_d = work2_d;
            done_d   = 1'b1;
            idx_d    = '0;
            state_d  = DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      work1_q  <= '0;
      work2_q  <= '0;
      notes1_q <= '0;
      notes2_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work1_q  <= work1_d;
      work2_q  <= work2_d;
      notes1_q <= notes1_d;
      notes2_q <= notes2_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign notes1     = notes1_q;
  assign notes2     = notes2_q;
  assign recording  = (state_q == RECORD);
  assign counting   = (state_q == COUNT_IN);
  assign done       = done_q;
  assign beat_idx   = idx_q;
  assign count_left = cnt_q;

endmodule
